// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS core: opcodes,
// architectural register indices and the default datapath width.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile32.sv
// Two-read / one-write register array with synchronous reset.
// Ports: clock, reset, raddr1/raddr2 -> rdata1/rdata2 (combinational),
//        waddr/wdata/wen commit on the rising edge; writes to $0 dropped.
module regfile32
    import mips_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wen,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    // $0 is cleared by reset and never written, so it always reads 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != AW'(REG_ZERO))) begin
            regs[waddr] <= wdata;
        end
    end

    // No write bypass: a same-cycle read sees the pre-edge value.
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/idecode32.sv
// Decode / register-file stage: operand reads, immediate extension and
// write-back of ALU result, load data or the jal link address.
// Ports: clock, reset (sync, active-high); Instruction, read_data,
//        ALU_result, opcplus4, Jal, RegWrite, MemtoReg, RegDst in;
//        read_data_1, read_data_2, imme_extend out.
module idecode32
    import mips_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int NUM_REGS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      Instruction,
    input  logic [WIDTH-1:0] read_data,
    input  logic [WIDTH-1:0] ALU_result,
    input  logic [WIDTH-1:0] opcplus4,
    input  logic             Jal,
    input  logic             RegWrite,
    input  logic             MemtoReg,
    input  logic             RegDst,
    output logic [WIDTH-1:0] read_data_1,
    output logic [WIDTH-1:0] read_data_2,
    output logic [WIDTH-1:0] imme_extend
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm;
    logic [REG_AW-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              zext;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign imm    = Instruction[15:0];

    always_comb begin
        waddr = rt;
        if (Jal) begin
            waddr = REG_RA;
        end else if (RegDst) begin
            waddr = rd;
        end
    end

    always_comb begin
        wdata = ALU_result;
        if (Jal) begin
            wdata = opcplus4;
        end else if (MemtoReg) begin
            wdata = read_data;
        end
    end

    // Logical immediates and sltiu are unsigned; everything else,
    // lui included, is sign-extended.
    always_comb begin
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: zext = 1'b1;
            default:                            zext = 1'b0;
        endcase
    end

    assign imme_extend = zext
        ? {{(WIDTH-16){1'b0}}, imm}
        : {{(WIDTH-16){imm[15]}}, imm};

    regfile32 #(
        .WIDTH   (WIDTH),
        .NUM_REGS(NUM_REGS),
        .AW      (REG_AW)
    ) u_rf (
        .clock (clock),
        .reset (reset),
        .raddr1(rs),
        .raddr2(rt),
        .waddr (waddr),
        .wdata (wdata),
        .wen   (RegWrite),
        .rdata1(read_data_1),
        .rdata2(read_data_2)
    );

endmodule

// File: tb/tb_idecode32.sv
// Directed testbench for idecode32: reset, write-back paths, $0 guard,
// jal link, immediate extension, back-to-back writes, reset mid-write.
module tb_idecode32;

    logic        clock;
    logic        reset;
    logic [31:0] Instruction;
    logic [31:0] read_data;
    logic [31:0] ALU_result;
    logic [31:0] opcplus4;
    logic        Jal;
    logic        RegWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] imme_extend;

    int total = 0;
    int bad   = 0;

    idecode32 dut (
        .clock      (clock),
        .reset      (reset),
        .Instruction(Instruction),
        .read_data  (read_data),
        .ALU_result (ALU_result),
        .opcplus4   (opcplus4),
        .Jal        (Jal),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2),
        .imme_extend(imme_extend)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [5:0] op,
                                       input logic [4:0] s,
                                       input logic [4:0] t,
                                       input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic idle();
        reset    = 1'b0;
        RegWrite = 1'b0;
        Jal      = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Read register r on both ports and compare against exp.
    task automatic chk_reg(input string nm, input logic [4:0] r,
                           input logic [31:0] exp);
        Instruction = mk(6'h00, r, r, 16'h0000);
        #1;
        total++;
        if (read_data_1 !== exp) begin
            bad++;
            $display("FAIL %s rd1 r%0d got=%h want=%h", nm, r, read_data_1, exp);
        end
        total++;
        if (read_data_2 !== exp) begin
            bad++;
            $display("FAIL %s rd2 r%0d got=%h want=%h", nm, r, read_data_2, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        read_data   = 32'h0;
        ALU_result  = 32'h0;
        opcplus4    = 32'h0;
        Instruction = 32'h01095020;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_add got=%h/%h want=0/0", read_data_1, read_data_2);
        end
        for (int i = 0; i < 32; i++) begin
            chk_reg("reset_all", 5'(i), 32'h0);
        end
    endtask

    task automatic test_rtype();
        idle();
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        ALU_result  = 32'h12345678;
        read_data   = 32'h99999999;
        Instruction = mk(6'h00, 5'd10, 5'd3, {5'd10, 11'h020});
        #1;
        total++;
        if (read_data_1 !== 32'h0) begin
            bad++;
            $display("FAIL rtype_same_cycle got=%h want=%h", read_data_1, 32'h0);
        end
        tick();
        RegWrite = 1'b0;
        chk_reg("rtype_wb", 5'd10, 32'h12345678);
        chk_reg("rtype_rt_untouched", 5'd3, 32'h0);
    endtask

    task automatic test_load();
        idle();
        RegWrite    = 1'b1;
        MemtoReg    = 1'b1;
        read_data   = 32'hDEADBEEF;
        ALU_result  = 32'h11111111;
        Instruction = mk(6'h23, 5'd8, 5'd8, {5'd10, 11'h000});
        tick();
        RegWrite = 1'b0;
        chk_reg("load_wb", 5'd8, 32'hDEADBEEF);
        chk_reg("load_rd_untouched", 5'd10, 32'h12345678);
    endtask

    task automatic test_zero();
        idle();
        RegWrite    = 1'b1;
        MemtoReg    = 1'b1;
        read_data   = 32'hCAFEF00D;
        Instruction = mk(6'h23, 5'd8, 5'd0, 16'h0000);
        tick();
        RegWrite = 1'b0;
        chk_reg("zero_guard", 5'd0, 32'h0);
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        MemtoReg    = 1'b0;
        ALU_result  = 32'h55555555;
        Instruction = mk(6'h00, 5'd1, 5'd2, {5'd0, 11'h020});
        tick();
        RegWrite = 1'b0;
        chk_reg("zero_guard_rd", 5'd0, 32'h0);
    endtask

    task automatic test_jal();
        idle();
        Jal         = 1'b1;
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        MemtoReg    = 1'b1;
        opcplus4    = 32'h00000044;
        read_data   = 32'hBADBAD00;
        ALU_result  = 32'h0BADF00D;
        Instruction = mk(6'h03, 5'd7, 5'd9, {5'd12, 11'h000});
        tick();
        idle();
        chk_reg("jal_link", 5'd31, 32'h00000044);
        chk_reg("jal_rd_ignored", 5'd12, 32'h0);
        chk_reg("jal_rt_ignored", 5'd9, 32'h0);
        chk_reg("jal_keeps_r10", 5'd10, 32'h12345678);
    endtask

    task automatic test_ext();
        logic [5:0]  ops  [8];
        logic [15:0] imms [8];
        logic [31:0] exps [8];
        ops[0] = 6'h08; imms[0] = 16'h8001; exps[0] = 32'hFFFF8001;
        ops[1] = 6'h0D; imms[1] = 16'h8001; exps[1] = 32'h00008001;
        ops[2] = 6'h0B; imms[2] = 16'h8001; exps[2] = 32'h00008001;
        ops[3] = 6'h23; imms[3] = 16'h7FFF; exps[3] = 32'h00007FFF;
        ops[4] = 6'h0C; imms[4] = 16'hF0F0; exps[4] = 32'h0000F0F0;
        ops[5] = 6'h0E; imms[5] = 16'h8000; exps[5] = 32'h00008000;
        ops[6] = 6'h0F; imms[6] = 16'h8001; exps[6] = 32'hFFFF8001;
        ops[7] = 6'h04; imms[7] = 16'hFFFE; exps[7] = 32'hFFFFFFFE;
        idle();
        for (int i = 0; i < 8; i++) begin
            Instruction = mk(ops[i], 5'd1, 5'd2, imms[i]);
            #1;
            total++;
            if (imme_extend !== exps[i]) begin
                bad++;
                $display("FAIL ext op=%h imm=%h got=%h want=%h",
                         ops[i], imms[i], imme_extend, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle();
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        ALU_result  = 32'h00000001;
        Instruction = mk(6'h00, 5'd1, 5'd0, {5'd1, 11'h020});
        tick();
        ALU_result  = 32'h00000002;
        Instruction = mk(6'h00, 5'd1, 5'd2, {5'd2, 11'h020});
        #1;
        total++;
        if (read_data_1 !== 32'h1 || read_data_2 !== 32'h0) begin
            bad++;
            $display("FAIL b2b_mid got=%h/%h want=1/0", read_data_1, read_data_2);
        end
        tick();
        RegWrite = 1'b0;
        chk_reg("b2b_r1", 5'd1, 32'h1);
        chk_reg("b2b_r2", 5'd2, 32'h2);
    endtask

    task automatic test_reset_mid();
        idle();
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        ALU_result  = 32'hA5A5A5A5;
        Instruction = mk(6'h00, 5'd5, 5'd5, {5'd5, 11'h020});
        reset       = 1'b1;
        tick();
        idle();
        chk_reg("rst_mid_r5", 5'd5, 32'h0);
        chk_reg("rst_mid_r1", 5'd1, 32'h0);
        chk_reg("rst_mid_r2", 5'd2, 32'h0);
        chk_reg("rst_mid_r8", 5'd8, 32'h0);
        chk_reg("rst_mid_r10", 5'd10, 32'h0);
        chk_reg("rst_mid_r31", 5'd31, 32'h0);
    endtask

    initial begin
        idle();
        Instruction = 32'h0;
        test_reset();
        test_rtype();
        test_load();
        test_zero();
        test_jal();
        test_ext();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
